cpu_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer for the 16-bit core.
- Fetches each instruction over a handshake, holds it in an internal instruction register, and drives the register file, ALU and data-memory strobes.
- Drives the program counter controls (pc_write_en, pc_mux, offset_val): exactly one PC update per retired instruction.
- Supports free-run, single-step and halt, with a memory-timeout bus error.

---
 rtl/cpu_ctrl_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit core: fetch handshake,
// instruction register, datapath strobes, PC update control, step/halt
// and memory-timeout bus error.
module cpu_ctrl_fsm #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step_mode,
   input  logic             step,
   output logic             imem_req,
   input  logic             imem_valid,
   input  logic [15:0]      imem_data,
   output logic [15:0]      ir_out,
   output logic             rf_read_en,
   output logic [1:0]       alu_op,
   input  logic             alu_zero,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic [1:0]       wb_sel,
   output logic             reg_write_en,
   output logic             pc_write_en,
   output logic             pc_mux,
   output logic [5:0]       offset_val,
   output logic             halted,
   output logic             bus_error,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired_count,
   output logic [2:0]       state_out
);

   // Wait counter only has to reach TIMEOUT-1 before the limit fires.
   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_NAND = 4'h2;
   localparam logic [3:0] OP_LHI  = 4'h3;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_NAND = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;
   localparam logic [1:0] ALU_IMM  = 2'b11;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_IMM = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t              state;
   state_t              retire_nx_c;
   logic [15:0]         ir;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [3:0]          op;
   logic                legal_c;

   assign op        = ir[15:12];
   assign ir_out    = ir;
   assign state_out = state;

   // Opcode legality and where to go after an instruction retires.
   always_comb begin
      legal_c = 1'b0;
      case (op)
         OP_ADD, OP_NAND, OP_LHI, OP_LW, OP_SW, OP_BEQ, OP_HLT: legal_c = 1'b1;
         default:                                               legal_c = 1'b0;
      endcase
      retire_nx_c = (run && !step_mode) ? S_FETCH : S_IDLE;
   end

   // State, instruction register, wait counter, error flag and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         ir            <= '0;
         wait_cnt      <= '0;
         bus_error     <= 1'b0;
         retired_count <= '0;
      end else begin
         if (pc_write_en && (retired_count != CNT_MAX))
            retired_count <= retired_count + CNT_W'(1);
         case (state)
            S_IDLE: begin
               wait_cnt <= '0;
               if (run && (!step_mode || step))
                  state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_valid) begin
                  ir       <= imem_data;
                  state    <= S_DECODE;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  bus_error <= 1'b1;
                  state     <= S_HALT;
                  wait_cnt  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_DECODE: begin
               if (op == OP_HLT)
                  state <= S_HALT;
               else if (!legal_c)
                  state <= retire_nx_c;
               else
                  state <= S_EXEC;
            end
            S_EXEC: begin
               case (op)
                  OP_ADD, OP_NAND, OP_LHI: state <= S_WB;
                  OP_LW, OP_SW:            state <= S_MEM;
                  OP_BEQ:                  state <= retire_nx_c;
                  default:                 state <= S_IDLE;
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  wait_cnt <= '0;
                  state    <= (op == OP_LW) ? S_WB : retire_nx_c;
               end else if (wait_cnt == WAIT_LAST) begin
                  bus_error <= 1'b1;
                  state     <= S_HALT;
                  wait_cnt  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_WB:    state <= retire_nx_c;
            S_HALT:  state <= S_HALT;
            default: begin
               state    <= S_IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // Strobe decode from state and instruction register.
   always_comb begin
      imem_req     = 1'b0;
      rf_read_en   = 1'b0;
      alu_op       = ALU_ADD;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      wb_sel       = WB_ALU;
      reg_write_en = 1'b0;
      pc_write_en  = 1'b0;
      pc_mux       = 1'b0;
      illegal_op   = 1'b0;
      halted       = 1'b0;
      offset_val   = ir[5:0];
      case (state)
         S_FETCH: imem_req = 1'b1;
         S_DECODE: begin
            rf_read_en = 1'b1;
            if (!legal_c) begin
               illegal_op  = 1'b1;
               pc_write_en = 1'b1;
            end
         end
         S_EXEC: begin
            case (op)
               OP_NAND: alu_op = ALU_NAND;
               OP_LHI:  alu_op = ALU_IMM;
               OP_BEQ: begin
                  alu_op      = ALU_SUB;
                  pc_write_en = 1'b1;
                  pc_mux      = alu_zero;
               end
               default: alu_op = ALU_ADD;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OP_SW);
            if (dmem_ready && (op == OP_SW))
               pc_write_en = 1'b1;
         end
         S_WB: begin
            reg_write_en = 1'b1;
            pc_write_en  = 1'b1;
            case (op)
               OP_LW:   wb_sel = WB_MEM;
               OP_LHI:  wb_sel = WB_IMM;
               default: wb_sel = WB_ALU;
            endcase
         end
         S_HALT:  halted = 1'b1;
         default: halted = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: each pushed instruction queues its
// expected retire-cycle strobes, checked when pc_write_en fires.
module tb_cpu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
   logic        imem_req;
   logic        imem_valid = 1'b0;
   logic [15:0] imem_data = '0;
   logic [15:0] ir_out;
   logic        rf_read_en;
   logic [1:0]  alu_op;
   logic        alu_zero = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready = 1'b0;
   logic [1:0]  wb_sel;
   logic        reg_write_en;
   logic        pc_write_en;
   logic        pc_mux;
   logic [5:0]  offset_val;
   logic        halted;
   logic        bus_error;
   logic        illegal_op;
   logic [15:0] retired_count;
   logic [2:0]  state_out;

   cpu_ctrl_fsm #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
      .imem_req(imem_req), .imem_valid(imem_valid), .imem_data(imem_data),
      .ir_out(ir_out), .rf_read_en(rf_read_en), .alu_op(alu_op),
      .alu_zero(alu_zero), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_ready(dmem_ready), .wb_sel(wb_sel), .reg_write_en(reg_write_en),
      .pc_write_en(pc_write_en), .pc_mux(pc_mux), .offset_val(offset_val),
      .halted(halted), .bus_error(bus_error), .illegal_op(illegal_op),
      .retired_count(retired_count), .state_out(state_out)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic       pcm;
      logic [5:0] off;
      logic       rw;
      logic [1:0] wb;
      logic       ill;
      logic       dwe;
      int         lat;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] prog[$];
   int          retire_cycs[$];
   int total = 0, bad = 0;
   int cyc = 0, drv_cyc = 0, dmem_delay = 0, dcnt = 0;
   int req_cnt = 0, ill_cnt = 0, stray = 0, run_len = 0, max_run = 0;
   exp_t e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bench model of the retire-cycle strobes for one instruction.
   task automatic push_instr(input logic [15:0] instr);
      exp_t x;
      prog.push_back(instr);
      x.pcm = 1'b0; x.off = instr[5:0]; x.rw = 1'b0; x.wb = 2'b00;
      x.ill = 1'b0; x.dwe = 1'b0; x.lat = 0;
      case (instr[15:12])
         4'h0, 4'h2: begin x.rw = 1'b1; x.lat = 4; end
         4'h3:       begin x.rw = 1'b1; x.wb = 2'b10; x.lat = 4; end
         4'h4:       begin x.rw = 1'b1; x.wb = 2'b01; x.lat = 5 + dmem_delay; end
         4'h5:       begin x.dwe = 1'b1; x.lat = 4 + dmem_delay; end
         4'h8:       begin x.pcm = alu_zero; x.lat = 3; end
         4'hF:       x.lat = -1;
         default:    begin x.ill = 1'b1; x.lat = 2; end
      endcase
      if (x.lat >= 0) sb.push_back(x);
   endtask

   always @(posedge clk) cyc++;

   // Instruction and data memory responders.
   always @(negedge clk) begin
      if (rst) begin
         imem_valid = 1'b0;
         dmem_ready = 1'b0;
         dcnt = 0;
      end else begin
         if (imem_valid && prog.size() > 0) void'(prog.pop_front());
         imem_valid = 1'b0;
         if (imem_req && prog.size() > 0) begin
            imem_valid = 1'b1;
            imem_data  = prog[0];
            drv_cyc    = cyc;
         end
         if (dmem_req) begin
            dmem_ready = (dcnt == dmem_delay);
            dcnt++;
         end else begin
            dmem_ready = 1'b0;
            dcnt = 0;
         end
      end
   end

   // Output monitor and scoreboard comparison at each retire.
   always @(negedge clk) begin
      #1;
      if (!rst) begin
         if (imem_req) req_cnt++;
         if (illegal_op) ill_cnt++;
         if (dmem_req) run_len++;
         else begin
            if (run_len > max_run) max_run = run_len;
            run_len = 0;
         end
         if (halted && (imem_req | rf_read_en | dmem_req | reg_write_en | pc_write_en | illegal_op))
            stray++;
         if (pc_write_en) begin
            retire_cycs.push_back(cyc);
            if (sb.size() == 0) chk("sb_unexpected_retire", 32'(sb.size()), 1);
            else begin
               e = sb.pop_front();
               chk("pc_mux",   32'(pc_mux),       32'(e.pcm));
               chk("offset",   32'(offset_val),   32'(e.off));
               chk("reg_we",   32'(reg_write_en), 32'(e.rw));
               chk("wb_sel",   32'(wb_sel),       32'(e.wb));
               chk("illegal",  32'(illegal_op),   32'(e.ill));
               chk("dmem_we",  32'(dmem_we),      32'(e.dwe));
               chk("latency",  32'(cyc - drv_cyc + 1), 32'(e.lat));
            end
         end
      end
   end

   task automatic tick;
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset;
      rst = 1'b1; run = 1'b0; step = 1'b0; step_mode = 1'b0;
      prog.delete(); sb.delete(); retire_cycs.delete();
      repeat (2) tick;
      req_cnt = 0; ill_cnt = 0; stray = 0; run_len = 0; max_run = 0;
      rst = 1'b0;
      tick;
   endtask

   task automatic wait_halted(input string tag);
      for (int i = 0; i < 60; i++) begin
         if (halted) break;
         tick;
      end
      chk(tag, 32'(halted), 1);
   endtask

   task automatic pulse_step;
      step = 1'b1;
      tick;
      step = 1'b0;
   endtask

   task automatic wait_retired(input int n);
      for (int i = 0; i < 30; i++) begin
         if (int'(retired_count) == n && state_out == 3'd0) break;
         tick;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      // reset state
      rst = 1'b1;
      tick;
      chk("rst_state", 32'(state_out), 0);
      chk("rst_ir", 32'(ir_out), 0);
      chk("rst_cnt", 32'(retired_count), 0);
      chk("rst_buserr", 32'(bus_error), 0);
      chk("rst_strobes", 32'({imem_req, rf_read_en, dmem_req, dmem_we, reg_write_en,
                              pc_write_en, pc_mux, illegal_op, alu_op, wb_sel, halted}), 0);

      // free-run ADD then NAND
      do_reset;
      push_instr(16'h0123); push_instr(16'h2456); push_instr(16'hF000);
      run = 1'b1;
      wait_halted("t1_halt");
      chk("t1_cnt", 32'(retired_count), 2);
      chk("t1_gap", 32'(retire_cycs.size() == 2 ? retire_cycs[1] - retire_cycs[0] : 0), 4);
      chk("t1_ir", 32'(ir_out), 32'h0000F000);
      chk("t1_buserr", 32'(bus_error), 0);
      chk("t1_sb_left", 32'(sb.size()), 0);

      // BEQ taken / not taken
      do_reset;
      alu_zero = 1'b1;
      push_instr(16'h803E); push_instr(16'hF000);
      run = 1'b1;
      wait_halted("t2a_halt");
      chk("t2a_cnt", 32'(retired_count), 1);
      chk("t2a_sb_left", 32'(sb.size()), 0);
      do_reset;
      alu_zero = 1'b0;
      push_instr(16'h803E); push_instr(16'hF000);
      run = 1'b1;
      wait_halted("t2b_halt");
      chk("t2b_cnt", 32'(retired_count), 1);
      chk("t2b_sb_left", 32'(sb.size()), 0);

      // LW / SW with delayed dmem_ready
      do_reset;
      dmem_delay = 3;
      push_instr(16'h4001); push_instr(16'h5002); push_instr(16'h3055); push_instr(16'hF000);
      run = 1'b1;
      wait_halted("t3_halt");
      chk("t3_dmem_hold", 32'(max_run), 4);
      chk("t3_cnt", 32'(retired_count), 3);
      chk("t3_sb_left", 32'(sb.size()), 0);

      // fetch timeout
      do_reset;
      run = 1'b1;
      wait_halted("t4_halt");
      chk("t4_fetch_cycles", 32'(req_cnt), 4);
      chk("t4_buserr", 32'(bus_error), 1);
      repeat (8) tick;
      chk("t4_stray", 32'(stray), 0);
      chk("t4_state", 32'(state_out), 6);
      do_reset;
      chk("t4_rst_buserr", 32'(bus_error), 0);
      chk("t4_rst_halted", 32'(halted), 0);

      // single-step
      do_reset;
      dmem_delay = 0;
      step_mode = 1'b1;
      push_instr(16'h0001); push_instr(16'h0002); push_instr(16'hF000);
      run = 1'b1;
      repeat (5) tick;
      chk("t5_wait_state", 32'(state_out), 0);
      chk("t5_wait_cnt", 32'(retired_count), 0);
      pulse_step;
      wait_retired(1);
      repeat (3) tick;
      chk("t5_step1_cnt", 32'(retired_count), 1);
      chk("t5_step1_state", 32'(state_out), 0);
      pulse_step;
      wait_retired(2);
      chk("t5_step2_cnt", 32'(retired_count), 2);
      pulse_step;
      wait_halted("t5_halt");
      chk("t5_final_cnt", 32'(retired_count), 2);
      chk("t5_sb_left", 32'(sb.size()), 0);

      // illegal opcode then HLT
      do_reset;
      push_instr(16'h7000); push_instr(16'h0111); push_instr(16'hF000);
      run = 1'b1;
      wait_halted("t6_halt");
      chk("t6_ill_pulses", 32'(ill_cnt), 1);
      chk("t6_cnt", 32'(retired_count), 2);
      chk("t6_sb_left", 32'(sb.size()), 0);

      // reset during MEM
      do_reset;
      dmem_delay = 3;
      push_instr(16'h4003);
      run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (dmem_req) break;
         tick;
      end
      chk("t7_mem_reach", 32'(dmem_req), 1);
      #2 rst = 1'b1;
      #1;
      chk("t7_dmem_drop", 32'(dmem_req), 0);
      chk("t7_state", 32'(state_out), 0);
      do_reset;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
